// File: rtl/merge_rr.sv
// Round-robin N:1 request merger: one master at a time owns the single slave port
// until the slave answers ready or the master withdraws its request.
module merge_rr #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    localparam int unsigned REQ_W    = 1 + ADDR_W + DATA_W + DATA_W / 8,
    localparam int unsigned RESP_W   = DATA_W + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS*REQ_W-1:0]    m_req,
    output logic [N_MASTERS*RESP_W-1:0]   m_resp,
    output logic [REQ_W-1:0]              s_req,
    input  logic [RESP_W-1:0]             s_resp,
    output logic [N_MASTERS-1:0]          m_grant
);

    localparam int unsigned PTR_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e               state_q;
    logic [N_MASTERS-1:0] grant_q;
    logic [PTR_W-1:0]     ptr_q;

    logic [N_MASTERS-1:0] valid;
    logic [N_MASTERS-1:0] win;
    logic                 win_found;
    logic [PTR_W-1:0]     ptr_adv;
    logic                 gnt_valid;

    // req = {valid, addr, wdata, wstrb}: valid is the top bit of each slot
    always_comb begin
        valid = '0;
        for (int i = 0; i < int'(N_MASTERS); i++) begin
            valid[i] = m_req[i*REQ_W + REQ_W - 1];
        end
    end

    // First pass covers [ptr, N-1], second pass wraps to [0, ptr-1].
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        for (int i = 0; i < int'(N_MASTERS); i++) begin
            if (!win_found && valid[i] && (PTR_W'(i) >= ptr_q)) begin
                win[i]    = 1'b1;
                win_found = 1'b1;
            end
        end
        for (int i = 0; i < int'(N_MASTERS); i++) begin
            if (!win_found && valid[i]) begin
                win[i]    = 1'b1;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_adv = '0;
        for (int i = 0; i < int'(N_MASTERS); i++) begin
            if (grant_q[i]) begin
                ptr_adv = (i + 1 < int'(N_MASTERS)) ? PTR_W'(i + 1) : '0;
            end
        end
    end

    always_comb begin
        s_req     = '0;
        m_resp    = '0;
        gnt_valid = 1'b0;
        if (state_q == StBusy) begin
            for (int i = 0; i < int'(N_MASTERS); i++) begin
                if (grant_q[i]) begin
                    s_req                       = m_req[i*REQ_W +: REQ_W];
                    m_resp[i*RESP_W +: RESP_W]  = s_resp;
                    gnt_valid                   = valid[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (win_found) begin
                        grant_q <= win;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    // Ready completes; a withdrawn request aborts. Both release the slave.
                    if (!gnt_valid || s_resp[0]) begin
                        grant_q <= '0;
                        ptr_q   <= ptr_adv;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign m_grant = grant_q;

endmodule

// File: tb/tb_merge_rr.sv
// Directed bench for merge_rr with 1, 2 and 4 masters (8-bit address and data).
module tb_merge_rr;

    localparam int RW = 18;  // 1 + 8 + 8 + 1
    localparam int PW = 9;   // 8 + 1

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // N = 2
    logic             rst2;
    logic [2*RW-1:0]  m_req2;
    logic [2*PW-1:0]  m_resp2;
    logic [RW-1:0]    s_req2;
    logic [PW-1:0]    s_resp2;
    logic [1:0]       grant2;

    // N = 4
    logic             rst4;
    logic [4*RW-1:0]  m_req4;
    logic [4*PW-1:0]  m_resp4;
    logic [RW-1:0]    s_req4;
    logic [PW-1:0]    s_resp4;
    logic [3:0]       grant4;

    // N = 1
    logic             rst1;
    logic [RW-1:0]    m_req1;
    logic [PW-1:0]    m_resp1;
    logic [RW-1:0]    s_req1;
    logic [PW-1:0]    s_resp1;
    logic [0:0]       grant1;

    merge_rr #(.N_MASTERS(2), .ADDR_W(8), .DATA_W(8)) u2 (
        .clk(clk), .rst(rst2), .m_req(m_req2), .m_resp(m_resp2),
        .s_req(s_req2), .s_resp(s_resp2), .m_grant(grant2)
    );

    merge_rr #(.N_MASTERS(4), .ADDR_W(8), .DATA_W(8)) u4 (
        .clk(clk), .rst(rst4), .m_req(m_req4), .m_resp(m_resp4),
        .s_req(s_req4), .s_resp(s_resp4), .m_grant(grant4)
    );

    merge_rr #(.N_MASTERS(1), .ADDR_W(8), .DATA_W(8)) u1 (
        .clk(clk), .rst(rst1), .m_req(m_req1), .m_resp(m_resp1),
        .s_req(s_req1), .s_resp(s_resp1), .m_grant(grant1)
    );

    function automatic logic [RW-1:0] rq(input logic v, input logic [7:0] a, input logic [7:0] d);
        return {v, a, d, 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [RW-1:0] a0, a1, a0_inv;
    logic [RW-1:0] r4 [4];
    int            order [5];

    initial begin
        a0     = rq(1'b1, 8'h10, 8'hA0);
        a1     = rq(1'b1, 8'h20, 8'hB1);
        a0_inv = rq(1'b0, 8'h10, 8'hA0);
        r4[0]  = rq(1'b1, 8'h40, 8'h00);
        r4[1]  = rq(1'b1, 8'h41, 8'h11);
        r4[2]  = rq(1'b1, 8'h42, 8'h22);
        r4[3]  = rq(1'b1, 8'h43, 8'h33);
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;

        rst2 = 1'b1; rst4 = 1'b1; rst1 = 1'b1;
        m_req2 = '0; m_req4 = '0; m_req1 = '0;
        s_resp2 = '0; s_resp4 = '0; s_resp1 = '0;
        cyc();
        cyc();

        // Two masters contend right after reset
        rst2 = 1'b0;
        #1;
        chk("n2_rst_grant", 64'(grant2), 64'h0);
        chk("n2_rst_sreq", 64'(s_req2), 64'h0);
        chk("n2_rst_mresp", 64'(m_resp2), 64'h0);
        m_req2 = {a1, a0};
        #1;
        chk("n2_c0_grant", 64'(grant2), 64'h0);
        chk("n2_c0_sreq", 64'(s_req2), 64'h0);
        cyc();
        #1;
        chk("n2_c1_grant", 64'(grant2), 64'h1);
        chk("n2_c1_sreq", 64'(s_req2), 64'(a0));
        cyc();
        s_resp2 = 9'h0B5;
        #1;
        chk("n2_c2_mresp", 64'(m_resp2), 64'({9'h000, 9'h0B5}));
        cyc();
        m_req2 = {a1, 18'h0};
        #1;
        chk("n2_c3_grant", 64'(grant2), 64'h0);
        chk("n2_c3_sreq", 64'(s_req2), 64'h0);
        chk("n2_idle_ready_blocked", 64'(m_resp2), 64'h0);
        cyc();
        s_resp2 = '0;
        #1;
        chk("n2_c4_grant", 64'(grant2), 64'h2);
        chk("n2_c4_sreq", 64'(s_req2), 64'(a1));
        s_resp2 = 9'h0B5;
        #1;
        chk("n2_c4_mresp", 64'(m_resp2), 64'({9'h0B5, 9'h000}));
        cyc();

        // Granted master withdraws mid-transaction
        m_req2 = {a1, a0};
        s_resp2 = '0;
        cyc();
        #1;
        chk("abort_grant", 64'(grant2), 64'h1);
        m_req2 = {a1, a0_inv};
        #1;
        chk("abort_sreq_mirror", 64'(s_req2), 64'(a0_inv));
        cyc();
        m_req2 = {a1, a0};
        #1;
        chk("abort_idle", 64'(grant2), 64'h0);
        cyc();
        #1;
        chk("abort_next_grant", 64'(grant2), 64'h2);
        s_resp2 = 9'h001;
        cyc();
        m_req2 = '0;
        s_resp2 = '0;

        // Reset in the third busy cycle, ready arrives afterwards
        m_req2 = {18'h0, a0};
        cyc();
        cyc();
        cyc();
        #1;
        chk("rst_busy3_grant", 64'(grant2), 64'h1);
        rst2 = 1'b1;
        cyc();
        rst2 = 1'b0;
        m_req2 = '0;
        s_resp2 = 9'h0B5;
        #1;
        chk("rst_drop_grant", 64'(grant2), 64'h0);
        chk("rst_drop_sreq", 64'(s_req2), 64'h0);
        chk("rst_drop_mresp", 64'(m_resp2), 64'h0);
        cyc();
        #1;
        chk("rst_drop_mresp2", 64'(m_resp2), 64'h0);

        // Slave stalls five cycles
        m_req2 = {a1, 18'h0};
        s_resp2 = 9'h066;
        cyc();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_grant", 64'(grant2), 64'h2);
            chk("stall_sreq", 64'(s_req2), 64'(a1));
            chk("stall_mresp", 64'(m_resp2), 64'({9'h066, 9'h000}));
            cyc();
        end
        s_resp2 = 9'h067;
        #1;
        chk("stall_6_sreq", 64'(s_req2), 64'(a1));
        chk("stall_6_mresp", 64'(m_resp2), 64'({9'h067, 9'h000}));
        cyc();
        m_req2 = '0;
        #1;
        chk("stall_done", 64'(grant2), 64'h0);

        // Four masters always valid, slave always ready
        rst4 = 1'b0;
        m_req4 = {r4[3], r4[2], r4[1], r4[0]};
        s_resp4 = 9'h1C3;
        #1;
        chk("n4_rst_grant", 64'(grant4), 64'h0);
        chk("n4_idle_mresp", 64'(m_resp4), 64'h0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            #1;
            chk("rr_grant", 64'(grant4), 64'h1 << order[k]);
            chk("rr_sreq", 64'(s_req4), 64'(r4[order[k]]));
            chk("rr_mresp", 64'(m_resp4), 64'(9'h1C3) << (order[k] * PW));
            cyc();
            #1;
            chk("rr_gap", 64'(grant4), 64'h0);
            chk("rr_gap_mresp", 64'(m_resp4), 64'h0);
        end

        // Only m2 valid: reach ptr=3, then wrap back to m2
        m_req4 = {18'h0, r4[2], 36'h0};
        cyc();
        #1;
        chk("only2_first", 64'(grant4), 64'h4);
        cyc();
        cyc();
        #1;
        chk("only2_wrap", 64'(grant4), 64'h4);
        cyc();
        m_req4 = {r4[3], r4[2], r4[1], r4[0]};
        cyc();
        #1;
        chk("ptr_is_3", 64'(grant4), 64'h8);
        cyc();

        // Single master
        rst1 = 1'b0;
        m_req1 = a1;
        #1;
        chk("n1_rst_grant", 64'(grant1), 64'h0);
        cyc();
        #1;
        chk("n1_grant", 64'(grant1), 64'h1);
        chk("n1_sreq", 64'(s_req1), 64'(a1));
        s_resp1 = 9'h0F1;
        #1;
        chk("n1_mresp", 64'(m_resp1), 64'h0F1);
        cyc();
        #1;
        chk("n1_idle", 64'(grant1), 64'h0);
        chk("n1_idle_mresp", 64'(m_resp1), 64'h0);
        cyc();
        #1;
        chk("n1_regrant", 64'(grant1), 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
